serial_monitor: RTL and testbench

Parametrised host-command monitor that sits between the UART byte FIFOs, system memory and the CPU control pins. It parses framed commands from the receive FIFO: load, dump, exec, plus the new checksum command and a NAK reply. Header field widths, memory width and echo are generics. All UART pacing is left to the FIFO/UART side, so the block carries no wait counters.

---
 rtl/serial_monitor.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_serial_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_monitor.sv
//==============================================================================
// Module      : serial_monitor
// Description : Host-command monitor between the UART byte FIFOs, system memory
//               and the CPU control pins. Parses framed LOAD / DUMP / EXEC /
//               SUM commands and answers anything else with a NAK byte.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_monitor #(
    parameter int MEM_ADDR_WIDTH = 18,
    parameter int ADDR_BYTES     = 3,
    parameter int LEN_BYTES      = 2,
    parameter int ECHO           = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      abort,
    input  logic                      rx_empty,
    input  logic [7:0]                rx_data,
    output logic                      rx_read,
    input  logic                      tx_full,
    output logic [7:0]                tx_data,
    output logic                      tx_write,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wdata,
    output logic                      mem_write,
    input  logic [7:0]                mem_rdata,
    output logic                      running,
    output logic                      cpu_reset,
    output logic                      cpu_halt,
    input  logic                      cpu_halted,
    output logic [MEM_ADDR_WIDTH-1:0] start_addr
);

    localparam int   c_H        = 1 + ADDR_BYTES + LEN_BYTES;
    localparam int   c_HDR_W    = 8 * c_H;
    localparam int   c_ADDR_HW  = 8 * ADDR_BYTES;
    localparam int   c_LEN_W    = 8 * LEN_BYTES;
    localparam bit   c_ECHO_ON  = (ECHO != 0);
    localparam logic [2:0] c_H_LAST   = 3'(c_H - 1);
    localparam logic [1:0] c_IDX_LAST = 2'(LEN_BYTES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_ADDR_INC = MEM_ADDR_WIDTH'(1);
    localparam logic [c_LEN_W-1:0]        c_LEN_ONE  = c_LEN_W'(1);

    typedef enum logic [3:0] {
        S_HDR       = 4'd0,
        S_DECODE    = 4'd1,
        S_LOAD      = 4'd2,
        S_DUMP_RD   = 4'd3,
        S_DUMP_WAIT = 4'd4,
        S_DUMP_TX   = 4'd5,
        S_SUM_RD    = 4'd6,
        S_SUM_WAIT  = 4'd7,
        S_SUM_ACC   = 4'd8,
        S_SUM_HI    = 4'd9,
        S_SUM_LO    = 4'd10,
        S_EXEC_W    = 4'd11,
        S_START     = 4'd12,
        S_RUN       = 4'd13,
        S_NAK       = 4'd14
    } state_t;

    state_t                    r_state;
    logic [2:0]                r_hcnt;
    logic [c_HDR_W-1:0]        r_hdr;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [c_LEN_W-1:0]        r_len;
    logic [15:0]               r_sum;
    logic [1:0]                r_idx;
    logic                      r_first;

    logic [7:0]         w_cmd;
    logic [c_ADDR_HW-1:0] w_hdr_addr;
    logic [c_LEN_W-1:0] w_hdr_len;
    logic [31:0]        w_addr32;
    logic [15:0]        w_len16;
    logic [7:0]         w_exec_byte;
    logic               w_rx_ok;
    logic               w_len_last;
    logic               w_unused;

    // Header fields as laid out in the shift register: cmd first, len last.
    assign w_cmd      = r_hdr[c_HDR_W-1 -: 8];
    assign w_hdr_addr = r_hdr[c_LEN_W +: c_ADDR_HW];
    assign w_hdr_len  = r_hdr[c_LEN_W-1:0];
    assign w_addr32   = 32'(w_hdr_addr);
    assign w_len16    = 16'(r_len);

    // A byte can be taken when one is waiting and, with echo on, TX has room.
    assign w_rx_ok    = !rx_empty && (!c_ECHO_ON || !tx_full);
    assign w_len_last = (r_len == c_LEN_ONE);

    // Only cmd[2:0] selects a command; upper header address bits are dropped.
    assign w_unused   = ^{w_cmd[7:3], w_addr32};

    // EXEC writes the length field big-endian: index 0 carries the MSB.
    always_comb begin
        w_exec_byte = w_len16[7:0];
        if ((LEN_BYTES == 2) && (r_idx == 2'd0)) begin
            w_exec_byte = w_len16[15:8];
        end
    end

    // Command state machine; every output is a register driven from here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_HDR;
            r_hcnt     <= '0;
            r_hdr      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_first    <= 1'b0;
            rx_read    <= 1'b0;
            tx_write   <= 1'b0;
            tx_data    <= '0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            running    <= 1'b0;
            cpu_reset  <= 1'b0;
            cpu_halt   <= 1'b1;
            start_addr <= '0;
        end else if (abort) begin
            // Abort beats everything: drop all strobes and reclaim the CPU.
            r_state   <= S_HDR;
            r_hcnt    <= '0;
            rx_read   <= 1'b0;
            tx_write  <= 1'b0;
            mem_write <= 1'b0;
            cpu_reset <= 1'b0;
            running   <= 1'b0;
            cpu_halt  <= 1'b1;
        end else begin
            rx_read   <= 1'b0;
            tx_write  <= 1'b0;
            mem_write <= 1'b0;
            cpu_reset <= 1'b0;

            case (r_state)
                S_HDR: begin
                    if (w_rx_ok) begin
                        rx_read  <= 1'b1;
                        tx_write <= c_ECHO_ON;
                        tx_data  <= rx_data;
                        r_hdr    <= {r_hdr[c_HDR_W-9:0], rx_data};
                        if (r_hcnt == c_H_LAST) begin
                            r_hcnt  <= '0;
                            r_state <= S_DECODE;
                        end else begin
                            r_hcnt <= r_hcnt + 3'd1;
                        end
                    end
                end

                S_DECODE: begin
                    r_addr <= w_addr32[MEM_ADDR_WIDTH-1:0];
                    r_len  <= w_hdr_len;
                    r_sum  <= '0;
                    r_idx  <= '0;
                    case (w_cmd[2:0])
                        3'd1:    r_state <= (w_hdr_len == '0) ? S_HDR : S_LOAD;
                        3'd2:    r_state <= (w_hdr_len == '0) ? S_HDR : S_DUMP_RD;
                        3'd3:    r_state <= S_EXEC_W;
                        3'd4:    r_state <= (w_hdr_len == '0) ? S_SUM_HI : S_SUM_RD;
                        default: r_state <= S_NAK;
                    endcase
                end

                S_LOAD: begin
                    if (w_rx_ok) begin
                        rx_read   <= 1'b1;
                        tx_write  <= c_ECHO_ON;
                        tx_data   <= rx_data;
                        mem_write <= 1'b1;
                        mem_waddr <= r_addr;
                        mem_wdata <= rx_data;
                        r_addr    <= r_addr + c_ADDR_INC;
                        r_len     <= r_len - c_LEN_ONE;
                        if (w_len_last) begin
                            r_state <= S_HDR;
                        end
                    end
                end

                S_DUMP_RD: begin
                    mem_raddr <= r_addr;
                    r_state   <= S_DUMP_WAIT;
                end

                S_DUMP_WAIT: r_state <= S_DUMP_TX;

                S_DUMP_TX: begin
                    if (!tx_full) begin
                        tx_write <= 1'b1;
                        tx_data  <= mem_rdata;
                        r_addr   <= r_addr + c_ADDR_INC;
                        r_len    <= r_len - c_LEN_ONE;
                        r_state  <= w_len_last ? S_HDR : S_DUMP_RD;
                    end
                end

                S_SUM_RD: begin
                    mem_raddr <= r_addr;
                    r_state   <= S_SUM_WAIT;
                end

                S_SUM_WAIT: r_state <= S_SUM_ACC;

                S_SUM_ACC: begin
                    r_sum   <= r_sum + {8'h00, mem_rdata};
                    r_addr  <= r_addr + c_ADDR_INC;
                    r_len   <= r_len - c_LEN_ONE;
                    r_state <= w_len_last ? S_SUM_HI : S_SUM_RD;
                end

                S_SUM_HI: begin
                    if (!tx_full) begin
                        tx_write <= 1'b1;
                        tx_data  <= r_sum[15:8];
                        r_state  <= S_SUM_LO;
                    end
                end

                S_SUM_LO: begin
                    if (!tx_full) begin
                        tx_write <= 1'b1;
                        tx_data  <= r_sum[7:0];
                        r_state  <= S_HDR;
                    end
                end

                S_EXEC_W: begin
                    mem_write <= 1'b1;
                    mem_waddr <= MEM_ADDR_WIDTH'(r_idx);
                    mem_wdata <= w_exec_byte;
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= S_START;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end

                S_START: begin
                    cpu_reset  <= 1'b1;
                    cpu_halt   <= 1'b0;
                    running    <= 1'b1;
                    start_addr <= r_addr;
                    r_first    <= 1'b1;
                    r_state    <= S_RUN;
                end

                S_RUN: begin
                    // The halt input may still be stale from before the start pulse.
                    r_first <= 1'b0;
                    if (!r_first && cpu_halted) begin
                        running  <= 1'b0;
                        cpu_halt <= 1'b1;
                        r_state  <= S_HDR;
                    end
                end

                S_NAK: begin
                    if (!tx_full) begin
                        tx_write <= 1'b1;
                        tx_data  <= 8'hFF;
                        r_state  <= S_HDR;
                    end
                end

                default: r_state <= S_HDR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_monitor.sv
//==============================================================================
// Module      : tb_serial_monitor
// Description : Directed bench for serial_monitor with FIFO/memory models and
//               a TX scoreboard of expected bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_monitor;

    localparam int MAW = 18;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           abort;
    logic           rx_empty = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_read;
    logic           tx_full;
    logic [7:0]     tx_data;
    logic           tx_write;
    logic [MAW-1:0] mem_raddr;
    logic [MAW-1:0] mem_waddr;
    logic [7:0]     mem_wdata;
    logic           mem_write;
    logic [7:0]     mem_rdata;
    logic           running;
    logic           cpu_reset;
    logic           cpu_halt;
    logic           cpu_halted;
    logic [MAW-1:0] start_addr;

    logic [7:0] mem [0:(1<<MAW)-1];
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int         total = 0;
    int         bad = 0;
    int         n_rst_pulse = 0;
    logic       txf_at_edge;

    serial_monitor #(
        .MEM_ADDR_WIDTH(MAW),
        .ADDR_BYTES(3),
        .LEN_BYTES(2),
        .ECHO(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .abort(abort),
        .rx_empty(rx_empty),
        .rx_data(rx_data),
        .rx_read(rx_read),
        .tx_full(tx_full),
        .tx_data(tx_data),
        .tx_write(tx_write),
        .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .running(running),
        .cpu_reset(cpu_reset),
        .cpu_halt(cpu_halt),
        .cpu_halted(cpu_halted),
        .start_addr(start_addr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    // Show-ahead RX FIFO head, refreshed between active edges.
    always @(negedge clk) begin
        rx_empty = (rxq.size() == 0);
        rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end

    // Strobe monitor: pops RX, scores TX bytes, counts start pulses.
    always @(posedge clk) begin
        txf_at_edge = tx_full;
        #1;
        if (rx_read) begin
            chk("rx_pop_nonempty", 32'(rxq.size() != 0), 32'd1);
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        if (tx_write) begin
            chk("tx_write_not_full", 32'(txf_at_edge), 32'd0);
            chk("tx_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) chk("tx_byte", 32'(tx_data), 32'(expq.pop_front()));
        end
        if (cpu_reset) n_rst_pulse++;
        if (running) chk("quiet_while_running", {29'd0, rx_read, tx_write, mem_write}, 32'd0);
    end

    // Overall time limit.
    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input bit echo);
        rxq.push_back(b);
        if (echo) expq.push_back(b);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] a, input logic [15:0] l);
        send(cmd, 1'b1);
        send(a[23:16], 1'b1);
        send(a[15:8], 1'b1);
        send(a[7:0], 1'b1);
        send(l[15:8], 1'b1);
        send(l[7:0], 1'b1);
    endtask

    task automatic expect_tx(input logic [7:0] b);
        expq.push_back(b);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rxq.size() != 0 || expq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL drain_timeout rx_left=%0d tx_left=%0d", rxq.size(), expq.size());
            rxq.delete();
            expq.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_tx_write", 32'(tx_write), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_start_addr", 32'(start_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        int n;
        reset_n    = 1'b0;
        abort      = 1'b0;
        tx_full    = 1'b0;
        cpu_halted = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset_n = 1'b1;
        @(negedge clk);

        // LOAD three bytes then DUMP them back.
        hdr(8'h01, 24'h000010, 16'h0003);
        send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1);
        drain(200);
        chk("load_m10", 32'(mem[18'h10]), 32'hAA);
        chk("load_m11", 32'(mem[18'h11]), 32'hBB);
        chk("load_m12", 32'(mem[18'h12]), 32'hCC);
        hdr(8'h02, 24'h000010, 16'h0003);
        expect_tx(8'hAA); expect_tx(8'hBB); expect_tx(8'hCC);
        drain(200);

        // SUM of FF,FF,03 = 0x0201, then len=0 gives 00 00.
        hdr(8'h01, 24'h000010, 16'h0003);
        send(8'hFF, 1'b1); send(8'hFF, 1'b1); send(8'h03, 1'b1);
        drain(200);
        hdr(8'h04, 24'h000010, 16'h0003);
        expect_tx(8'h02); expect_tx(8'h01);
        drain(200);
        hdr(8'h04, 24'h000010, 16'h0000);
        expect_tx(8'h00); expect_tx(8'h00);
        drain(200);

        // Address wrap during LOAD, then an unknown command.
        hdr(8'h01, 24'h03FFFF, 16'h0002);
        send(8'h11, 1'b1); send(8'h22, 1'b1);
        drain(200);
        chk("wrap_top", 32'(mem[18'h3FFFF]), 32'h11);
        chk("wrap_zero", 32'(mem[18'h00000]), 32'h22);
        hdr(8'h07, 24'h000000, 16'h0000);
        expect_tx(8'hFF);
        drain(200);

        // EXEC: length bytes written to mem[0..1], CPU started at 0x2000.
        n_rst_pulse = 0;
        hdr(8'h03, 24'h002000, 16'h1234);
        drain(200);
        n = 0;
        while (running !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("exec_running", 32'(running), 32'd1);
        chk("exec_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("exec_start_addr", 32'(start_addr), 32'h2000);
        chk("exec_m0", 32'(mem[18'h0]), 32'h12);
        chk("exec_m1", 32'(mem[18'h1]), 32'h34);
        repeat (50) @(negedge clk);
        chk("exec_single_pulse", 32'(n_rst_pulse), 32'd1);
        cpu_halted = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_running", 32'(running), 32'd0);
        chk("halt_cpu_halt", 32'(cpu_halt), 32'd1);
        @(negedge clk);
        cpu_halted = 1'b0;
        hdr(8'h02, 24'h000000, 16'h0002);
        expect_tx(8'h12); expect_tx(8'h34);
        drain(200);

        // Backpressure on a 4-byte DUMP.
        hdr(8'h01, 24'h000040, 16'h0004);
        send(8'h5A, 1'b1); send(8'hA5, 1'b1); send(8'h3C, 1'b1); send(8'hC3, 1'b1);
        drain(200);
        hdr(8'h02, 24'h000040, 16'h0004);
        expect_tx(8'h5A); expect_tx(8'hA5); expect_tx(8'h3C); expect_tx(8'hC3);
        n = 0;
        while (expq.size() > 4 && n < 50) begin @(negedge clk); n++; end
        tx_full = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_held", 32'(expq.size()), 32'd4);
        tx_full = 1'b0;
        drain(200);

        // Abort in the middle of a LOAD.
        hdr(8'h01, 24'h000050, 16'h0004);
        send(8'h01, 1'b1); send(8'h02, 1'b1);
        drain(200);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_running", 32'(running), 32'd0);
        chk("abort_cpu_halt", 32'(cpu_halt), 32'd1);
        chk("abort_strobes", {29'd0, rx_read, tx_write, mem_write}, 32'd0);
        chk("abort_m50", 32'(mem[18'h50]), 32'h01);
        chk("abort_m51", 32'(mem[18'h51]), 32'h02);
        hdr(8'h02, 24'h000050, 16'h0002);
        expect_tx(8'h01); expect_tx(8'h02);
        drain(200);

        // Reset while the CPU is running.
        hdr(8'h03, 24'h000123, 16'h0000);
        drain(200);
        chk("run2_running", 32'(running), 32'd1);
        chk("run2_start_addr", 32'(start_addr), 32'h123);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        hdr(8'h02, 24'h000040, 16'h0002);
        expect_tx(8'h5A); expect_tx(8'hA5);
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
